branch_history_table: RTL and testbench
=======================================

# branch_history_table

Bimodal branch predictor for the five-stage RV64 pipeline. It supplies the `prediction` bit that the decode stage hands to the ID/EX register. It also consumes the resolved outcome and the carried `prediction_reg` coming back out of EX, so it closes the prediction loop. It trains a table of 2-bit saturating counters and raises `mispredict` so the pipeline control can flush IF/ID and ID/EX.

## Interface
Parameters:
- `ENTRIES`, 64: number of 2-bit counters; power of two, 4..1024.
- `INDEX_W`, 6: log2(`ENTRIES`); must match.
- `INIT_STATE`, 2'b01: counter value loaded on reset (weakly not-taken).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `lookup_pc`  in  64  PC of the instruction in ID.
- `prediction`  out  1  predicted direction for `lookup_pc` (1 = taken).
- `update_valid`  in  1  a conditional branch resolved in EX this cycle.
- `update_pc`  in  64  PC of the resolving branch (ID/EX `pc_reg`).
- `update_taken`  in  1  actual outcome from EX.
- `update_prediction`  in  1  prediction carried with the branch (ID/EX `prediction_reg`).
- `mispredict`  out  1  outcome differs from the carried prediction.
- `branch_count`  out  32  resolved branches seen (stats).
- `mispredict_count`  out  32  mispredictions seen (stats).

## Operation
- Index:
  - lookup index = `lookup_pc[INDEX_W+1:2]`.
  - update index = `update_pc[INDEX_W+1:2]`.
  - PC bits [1:0] and bits above `INDEX_W+1` are ignored; aliasing is permitted.
- Counter states:
  - 00 strong not-taken
  - 01 weak not-taken
  - 10 weak taken
  - 11 strong taken
- `prediction` = MSB of the indexed counter. It is combinational from `lookup_pc` and the registered table.
- Update, at posedge when `update_valid`=1:
  - `update_taken`=1: counter increments, saturating at 11.
  - `update_taken`=0: counter decrements, saturating at 00.
  - `update_valid`=0: table unchanged.
- `mispredict` = `update_valid` & (`update_taken` != `update_prediction`). It is combinational and is 0 whenever `update_valid`=0.
- `mispredict` is computed against the carried prediction, not the current table value, so aliasing or intervening updates cannot mask a wrong fetch.
- Stats counters:
  - `branch_count` increments on each posedge with `update_valid`=1.
  - `mispredict_count` increments on each posedge with `mispredict`=1.
  - Both saturate at 32'hFFFFFFFF and never wrap.

## Timing
- Reset (`reset_n`=0, asynchronous, takes effect without a clock edge):
  - every counter loads `INIT_STATE`;
  - `branch_count` = 0 and `mispredict_count` = 0;
  - `prediction` settles to `INIT_STATE[1]`.
  - Assertion mid-update discards that update.
- Lookup latency: 0 cycles (same-cycle combinational read).
- Update latency: 1 cycle. The new counter value is visible to lookup from the cycle after the `update_valid` edge.
- Same-index lookup and update in one cycle: `prediction` returns the pre-update value (read-before-write). No bypass.
- `mispredict`: valid in the same cycle as `update_valid`. Pipeline control samples it at the same posedge as the update.
- Update with X on `update_pc` while `update_valid`=0 must not disturb state.

## Configuration
- `BHT_STATS_EN` defined:
  - `branch_count` and `mispredict_count` are implemented as described above.
- `BHT_STATS_EN` undefined:
  - both counter registers are removed;
  - both outputs are tied to 32'h0;
  - prediction and `mispredict` behaviour is identical.

## Test plan
- Reset default: assert `reset_n`=0 mid-run with an update pending, then release. Expect `prediction`=0 for `lookup_pc`=0x40 and 0x1000, and both counts = 0 (with `BHT_STATS_EN`).
- Train and saturate at pc 0x40:
  - one taken update → next cycle `prediction`=1;
  - two more taken updates (counter at 11), then one not-taken → `prediction` still 1;
  - second not-taken → `prediction`=0.
- Mispredict flag: `update_valid`=1, taken=1, carried prediction=0 → `mispredict`=1 that cycle and `mispredict_count`=1 after the edge. taken=0 with prediction=0 → `mispredict`=0. `update_valid`=0 with taken≠prediction → `mispredict`=0.
- Aliasing: one taken update at 0x40 → lookup 0x140 (same index with `ENTRIES`=64) returns 1; lookup 0x44 still returns 0.
- Read-before-write: `lookup_pc`=`update_pc`=0x80 with a taken update from 01 → `prediction`=0 in that cycle and 1 in the next.
- Stats saturation: force both counts to 32'hFFFFFFFE via 2 mispredicting updates after preload (or a hierarchical deposit) → both read 32'hFFFFFFFF and hold. Rebuild without `BHT_STATS_EN` → both read 0 throughout.

Source files
------------

// File: rtl/branch_history_table.sv
// branch_history_table: bimodal branch predictor built from 2-bit saturating
// counters. A lookup reads the counter for the PC in ID in the same cycle.
// The branch resolving in EX trains its counter at the clock edge. A
// mispredict is flagged against the prediction carried down the pipe.
//
// Optional feature macro: BHT_STATS_EN. When it is defined, resolved-branch
// and misprediction statistics counters are implemented. When it is not
// defined, both statistics outputs are tied to zero.
module branch_history_table #(
  parameter int          ENTRIES    = 64,
  parameter int          INDEX_W    = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] lookup_pc,
  output logic        prediction,
  input  logic        update_valid,
  input  logic [63:0] update_pc,
  input  logic        update_taken,
  input  logic        update_prediction,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic [1:0]         table_q [ENTRIES];
  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] update_idx;
  logic [1:0]         update_cur;
  logic [1:0]         update_next;

  // PC bits [1:0] and the bits above the index are ignored, so aliasing is
  // allowed. These bits are folded here only to show that dropping them is
  // deliberate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[63:INDEX_W+2], lookup_pc[1:0],
                            update_pc[63:INDEX_W+2], update_pc[1:0]};

  assign lookup_idx = lookup_pc[INDEX_W+1:2];
  assign update_idx = update_pc[INDEX_W+1:2];

  // Read-before-write: the lookup sees the registered table, with no bypass
  // from an update happening in the same cycle.
  assign prediction = table_q[lookup_idx][1];

  // The mispredict check uses the carried prediction, not the current table
  // value. This way aliasing or a later retrain cannot hide a wrong fetch.
  assign mispredict = update_valid & (update_taken != update_prediction);

  // Saturating increment or decrement of the counter being trained.
  // NOTE: every path of a combinational block assigns its outputs, starting
  // from a default, so no latch can be inferred.
  always_comb begin
    update_cur  = table_q[update_idx];
    update_next = update_cur;
    if (update_taken) begin
      if (update_cur != 2'b11) update_next = update_cur + 2'b01;
    end else begin
      if (update_cur != 2'b00) update_next = update_cur - 2'b01;
    end
  end

  // Counter table. The index is used only when update_valid is 1, so an X on
  // update_pc while idle cannot corrupt an entry.
  // NOTE: this table is built from flops and not from a RAM macro, because
  // every entry must load INIT_STATE when reset is asserted. For the same
  // reason the table is reset in a loop. State updates use non-blocking
  // assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= INIT_STATE;
    end else if (update_valid) begin
      table_q[update_idx] <= update_next;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  // Statistics counters. They saturate at all-ones and never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count_q     <= 32'h0;
      mispredict_count_q <= 32'h0;
    end else begin
      if (update_valid && (branch_count_q != 32'hFFFF_FFFF))
        branch_count_q <= branch_count_q + 32'h1;
      if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF))
        mispredict_count_q <= mispredict_count_q + 32'h1;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = 32'h0;
  assign mispredict_count = 32'h0;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Directed testbench for branch_history_table with ENTRIES=64.
// It uses a vector table for training, aliasing and mispredict behaviour.
// Hand-written sequences cover asynchronous reset during an update, an X PC
// while idle, and saturation of the statistics counters. The expected
// statistics follow BHT_STATS_EN: the real counts when it is defined, zero
// when it is not.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] lookup_pc;
  logic        prediction;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic        update_prediction;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_branch = 32'h0;
  logic [31:0] model_mis    = 32'h0;

  always #5 clk = ~clk;

  branch_history_table #(.ENTRIES(64), .INDEX_W(6), .INIT_STATE(2'b01)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .lookup_pc         (lookup_pc),
    .prediction        (prediction),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_prediction (update_prediction),
    .mispredict        (mispredict),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  typedef struct {
    logic        valid;
    logic [63:0] upc;
    logic        taken;
    logic        carried;
    logic [63:0] lpc;
    logic        exp_pred;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input logic [31:0] m);
`ifdef BHT_STATS_EN
    return m;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    check({tag, " branch_count"}, {32'h0, branch_count}, {32'h0, exp_stat(model_branch)});
    check({tag, " mispredict_count"}, {32'h0, mispredict_count}, {32'h0, exp_stat(model_mis)});
  endtask

  initial begin
    // Index for ENTRIES=64 is pc[7:2]: 0x40 and 0x140 -> 16, 0x44 -> 17, 0x80 -> 32.
    // Every counter starts at 01 (weak not-taken).
    vecs[0]  = '{1'b1, 64'h40,  1'b1, 1'b0, 64'h40,  1'b0, 1'b1}; // 16: 01->10
    vecs[1]  = '{1'b0, 64'h40,  1'b1, 1'b0, 64'h40,  1'b1, 1'b0}; // idle, taken!=pred
    vecs[2]  = '{1'b1, 64'h40,  1'b1, 1'b1, 64'h140, 1'b1, 1'b0}; // alias, 10->11
    vecs[3]  = '{1'b1, 64'h40,  1'b1, 1'b1, 64'h44,  1'b0, 1'b0}; // 11 holds; 17 untouched
    vecs[4]  = '{1'b1, 64'h40,  1'b0, 1'b1, 64'h40,  1'b1, 1'b1}; // 11->10
    vecs[5]  = '{1'b1, 64'h40,  1'b0, 1'b1, 64'h40,  1'b1, 1'b1}; // 10->01
    vecs[6]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h40,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 64'h80,  1'b1, 1'b0, 64'h80,  1'b0, 1'b1}; // read-before-write
    vecs[8]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h80,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, 64'h44,  1'b0, 1'b0, 64'h44,  1'b0, 1'b0}; // 01->00
    vecs[10] = '{1'b1, 64'h44,  1'b0, 1'b0, 64'h44,  1'b0, 1'b0}; // 00 holds
    vecs[11] = '{1'b1, 64'h44,  1'b1, 1'b0, 64'h44,  1'b0, 1'b1}; // 00->01
    vecs[12] = '{1'b0, 64'h0,   1'b0, 1'b1, 64'h44,  1'b0, 1'b0};

    reset_n = 1'b0;
    lookup_pc = 64'h40;
    update_valid = 1'b0;
    update_pc = 64'h0;
    update_taken = 1'b0;
    update_prediction = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset pred 0x40", {63'h0, prediction}, 64'h0);
    check_stats("reset");

    foreach (vecs[i]) begin
      @(negedge clk);
      update_valid      = vecs[i].valid;
      update_pc         = vecs[i].upc;
      update_taken      = vecs[i].taken;
      update_prediction = vecs[i].carried;
      lookup_pc         = vecs[i].lpc;
      #1;
      check($sformatf("vec%0d prediction", i), {63'h0, prediction}, {63'h0, vecs[i].exp_pred});
      check($sformatf("vec%0d mispredict", i), {63'h0, mispredict}, {63'h0, vecs[i].exp_mis});
      if (vecs[i].valid) model_branch++;
      if (vecs[i].exp_mis) model_mis++;
      @(posedge clk);
      #1;
      check_stats($sformatf("vec%0d", i));
    end

    // Assert reset asynchronously while a taken update to 0x40 is pending.
    // Entry 32 (0x80) is currently 10 and must return to 01.
    @(negedge clk);
    update_valid = 1'b1;
    update_pc = 64'h40;
    update_taken = 1'b1;
    update_prediction = 1'b0;
    lookup_pc = 64'h80;
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset pred 0x80", {63'h0, prediction}, 64'h0);
    model_branch = 32'h0;
    model_mis = 32'h0;
    check_stats("async reset");
    @(posedge clk);
    @(negedge clk);
    update_valid = 1'b0;
    reset_n = 1'b1;
    lookup_pc = 64'h40;
    #1;
    check("post reset pred 0x40", {63'h0, prediction}, 64'h0);
    lookup_pc = 64'h1000;
    #1;
    check("post reset pred 0x1000", {63'h0, prediction}, 64'h0);
    check_stats("post reset");

    // An X on update_pc while idle must leave the table untouched.
    update_pc = 'x;
    update_taken = 1'b1;
    update_prediction = 1'b0;
    lookup_pc = 64'h40;
    #1;
    check("idle X mispredict", {63'h0, mispredict}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("idle X pred 0x40", {63'h0, prediction}, 64'h0);
    check_stats("idle X");

`ifdef BHT_STATS_EN
    // Preload both counters close to the top, then drive mispredicting updates.
    @(negedge clk);
    dut.branch_count_q = 32'hFFFF_FFFE;
    dut.mispredict_count_q = 32'hFFFF_FFFE;
    update_valid = 1'b1;
    update_pc = 64'h200;
    update_taken = 1'b1;
    update_prediction = 1'b0;
    model_branch = 32'hFFFF_FFFF;
    model_mis = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_stats($sformatf("saturate%0d", k));
    end
    @(negedge clk);
    update_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
